// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: pan mode encoding.
package synth_pkg;

    typedef enum logic [1:0] {
        PAN_FIXED = 2'd0,
        PAN_TRI   = 2'd1,
        PAN_SAW   = 2'd2,
        PAN_RSVD  = 2'd3
    } pan_mode_e;

endpackage

// File: rtl/pan_sweep_if.sv
// Sample/pan bundle between the voice mixer and the auto-panner.
interface pan_sweep_if #(
    parameter int WIDTH     = 16,
    parameter int GAIN_BITS = 8
);
    logic signed [WIDTH-1:0] sample_in;
    logic                    in_ready;
    logic [1:0]              mode;
    logic [GAIN_BITS:0]      pan_pos;
    logic signed [WIDTH-1:0] out_L;
    logic signed [WIDTH-1:0] out_R;
    logic                    out_ready;
    logic [GAIN_BITS:0]      pos_out;

    modport master (
        output sample_in, in_ready, mode, pan_pos,
        input  out_L, out_R, out_ready, pos_out
    );

    modport slave (
        input  sample_in, in_ready, mode, pan_pos,
        output out_L, out_R, out_ready, pos_out
    );
endinterface

// File: rtl/pan_sweep_dff.sv
// Basic flops: dffr (sync reset) and dffre (sync reset with load enable).
module dffr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end
endmodule

module dffre #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= RST_VAL;
        else if (en) q <= d;
    end
endmodule

// File: rtl/pan_sweep_position_gen.sv
// Pan position generator: fixed, triangle or sawtooth sweep, advancing once per sample strobe.
module pan_position_gen
    import synth_pkg::*;
#(
    parameter int GAIN_BITS = 8,
    parameter int DWELL     = 4800,
    parameter int STEP      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [GAIN_BITS:0]   pan_pos,
    output logic [GAIN_BITS:0]   pos
);
    localparam int GW = GAIN_BITS + 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [GW-1:0] FULL     = GW'(2 ** GAIN_BITS);
    localparam logic [GW:0]   FULL_X   = (GW + 1)'(2 ** GAIN_BITS);
    localparam logic [GW:0]   STEP_X   = (GW + 1)'(STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    pan_mode_e     mode_e;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [GW-1:0] pos_nxt;
    logic          dir, dir_nxt;
    logic          wrap;
    logic [GW:0]   pos_up;

    assign mode_e = pan_mode_e'(mode);
    // One extra bit so pos + STEP can exceed FULL without wrapping.
    assign pos_up = {1'b0, pos} + STEP_X;

    dffr #(.W(CW))                            u_cnt (.clk(clk), .rst(reset), .d(cnt_nxt), .q(cnt));
    dffr #(.W(GW), .RST_VAL(GW'(FULL / 2)))   u_pos (.clk(clk), .rst(reset), .d(pos_nxt), .q(pos));
    dffr #(.W(1))                             u_dir (.clk(clk), .rst(reset), .d(dir_nxt), .q(dir));

    always_comb begin
        wrap    = (cnt == CNT_LAST);
        cnt_nxt = cnt;
        pos_nxt = pos;
        dir_nxt = dir;
        if (in_ready) begin
            case (mode_e)
                PAN_TRI: begin
                    cnt_nxt = wrap ? '0 : cnt + 1'b1;
                    if (wrap && !dir) begin
                        if (pos_up >= FULL_X) begin
                            pos_nxt = FULL;
                            dir_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos_up[GW-1:0];
                        end
                    end else if (wrap) begin
                        if ({1'b0, pos} <= STEP_X) begin
                            pos_nxt = '0;
                            dir_nxt = 1'b0;
                        end else begin
                            pos_nxt = pos - STEP_X[GW-1:0];
                        end
                    end
                end
                PAN_SAW: begin
                    cnt_nxt = wrap ? '0 : cnt + 1'b1;
                    if (wrap) pos_nxt = (pos_up > FULL_X) ? '0 : pos_up[GW-1:0];
                end
                default: begin
                    // Reserved encoding falls through here and acts as fixed.
                    cnt_nxt = '0;
                    pos_nxt = (pan_pos > FULL) ? FULL : pan_pos;
                end
            endcase
        end
    end
endmodule

// File: rtl/pan_sweep.sv
// Stereo auto-panner: two-stage gain-multiply pipeline driven by pan_position_gen.
module pan_sweep
    import synth_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int GAIN_BITS = 8,
    parameter int DWELL     = 4800,
    parameter int STEP      = 16
) (
    input  logic         clk,
    input  logic         reset,
    pan_sweep_if.slave   bus
);
    localparam int GW = GAIN_BITS + 1;
    localparam int PW = WIDTH + GAIN_BITS + 1;
    localparam logic [GW-1:0] FULL = GW'(2 ** GAIN_BITS);

    // Truncation to WIDTH is safe because the gain never exceeds FULL.
    function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] s,
                                                      input logic [GW-1:0] g);
        logic signed [PW-1:0] prod;
        prod = PW'(s) * PW'($signed({1'b0, g}));
        return prod[GAIN_BITS +: WIDTH];
    endfunction

    logic [GW-1:0]           pos;
    logic [GW-1:0]           gain_l, gain_r;
    logic signed [WIDTH-1:0] sample_p1;
    logic [GW-1:0]           gain_l_p1, gain_r_p1;
    logic                    vld_p1;
    logic signed [WIDTH-1:0] out_l_p2, out_r_p2;
    logic                    vld_p2;

    pan_position_gen #(
        .GAIN_BITS(GAIN_BITS),
        .DWELL    (DWELL),
        .STEP     (STEP)
    ) u_pos_gen (
        .clk     (clk),
        .reset   (reset),
        .in_ready(bus.in_ready),
        .mode    (bus.mode),
        .pan_pos (bus.pan_pos),
        .pos     (pos)
    );

    assign gain_l = pos;
    assign gain_r = FULL - pos;

    // Stage 1: capture sample with the gains of the pre-update position.
    dffre #(.W(WIDTH)) u_sample_p1 (.clk(clk), .rst(1'b0), .en(bus.in_ready), .d(bus.sample_in), .q(sample_p1));
    dffre #(.W(GW))    u_gain_l_p1 (.clk(clk), .rst(1'b0), .en(bus.in_ready), .d(gain_l), .q(gain_l_p1));
    dffre #(.W(GW))    u_gain_r_p1 (.clk(clk), .rst(1'b0), .en(bus.in_ready), .d(gain_r), .q(gain_r_p1));
    dffr  #(.W(1))     u_vld_p1    (.clk(clk), .rst(reset), .d(bus.in_ready), .q(vld_p1));

    // Stage 2: weighted outputs, held until the next valid sample.
    dffre #(.W(WIDTH)) u_out_l_p2 (.clk(clk), .rst(reset), .en(vld_p1), .d(scale(sample_p1, gain_l_p1)), .q(out_l_p2));
    dffre #(.W(WIDTH)) u_out_r_p2 (.clk(clk), .rst(reset), .en(vld_p1), .d(scale(sample_p1, gain_r_p1)), .q(out_r_p2));
    dffr  #(.W(1))     u_vld_p2   (.clk(clk), .rst(reset), .d(vld_p1), .q(vld_p2));

    assign bus.out_L     = out_l_p2;
    assign bus.out_R     = out_r_p2;
    assign bus.out_ready = vld_p2;
    assign bus.pos_out   = pos;
endmodule

// File: tb/tb_pan_sweep.sv
// Directed bench for pan_sweep with WIDTH=16, GAIN_BITS=8, DWELL=4, STEP=64.
module tb_pan_sweep;
    import synth_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pan_sweep_if #(.WIDTH(16), .GAIN_BITS(8)) bus ();

    pan_sweep #(.WIDTH(16), .GAIN_BITS(8), .DWELL(4), .STEP(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    int tri_seq[11] = '{128, 192, 256, 192, 128, 64, 0, 64, 128, 192, 256};
    int saw_seq[7]  = '{128, 192, 256, 0, 64, 128, 192};
    int stream_s[16] = '{32767, -32768, 1, -1, 0, 12345, -12345, 255,
                         -256, 100, -100, 20000, -20000, 7, -7, 16384};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Floor of s*g/256, computed with integer division plus a floor fix-up.
    function automatic int model(input int s, input int g);
        int p, q;
        p = s * g;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return q;
    endfunction

    task automatic strobe(input int s, input int pos_before, input int pos_after, input string tag);
        @(negedge clk);
        bus.sample_in = 16'(s);
        bus.in_ready  = 1'b1;
        @(negedge clk);
        bus.in_ready  = 1'b0;
        check({tag, ".pos"},   int'(bus.pos_out),   pos_after);
        check({tag, ".early"}, int'(bus.out_ready), 0);
        @(negedge clk);
        check({tag, ".rdy"}, int'(bus.out_ready), 1);
        check({tag, ".L"},   int'(bus.out_L), model(s, pos_before));
        check({tag, ".R"},   int'(bus.out_R), model(s, 256 - pos_before));
    endtask

    initial begin
        bus.sample_in = '0;
        bus.in_ready  = 1'b0;
        bus.mode      = PAN_FIXED;
        bus.pan_pos   = 9'd128;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.rdy", int'(bus.out_ready), 0);
        check("rst.L",   int'(bus.out_L), 0);
        check("rst.R",   int'(bus.out_R), 0);
        check("rst.pos", int'(bus.pos_out), 128);
        reset = 1'b0;

        strobe(16384, 128, 128, "centre");
        check("centre.L_hex", int'(bus.out_L), 32'h2000);

        bus.pan_pos = 9'd256;
        strobe(1000, 128, 256, "f256a");
        strobe(-32768, 256, 256, "f256");
        bus.pan_pos = 9'd300;
        strobe(-32768, 256, 256, "f300");
        bus.mode    = 2'd3;
        bus.pan_pos = 9'd0;
        strobe(100, 256, 0, "rsvd");
        bus.mode    = PAN_FIXED;
        bus.pan_pos = 9'd128;
        strobe(0, 0, 128, "pre_tri");

        bus.mode = PAN_TRI;
        for (int k = 1; k <= 40; k++)
            strobe(k * 1237 - 24000, tri_seq[(k - 1) / 4], tri_seq[k / 4], $sformatf("tri%0d", k));

        bus.mode    = PAN_FIXED;
        bus.pan_pos = 9'd128;
        strobe(500, 256, 128, "pre_saw");
        bus.mode = PAN_SAW;
        for (int k = 1; k <= 24; k++)
            strobe((k == 1) ? -1 : k * 900 - 11000, saw_seq[(k - 1) / 4], saw_seq[k / 4],
                   $sformatf("saw%0d", k));

        bus.mode    = PAN_FIXED;
        bus.pan_pos = 9'd64;
        strobe(7, 192, 64, "pre_stream");
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                check($sformatf("stream%0d.rdy", j - 2), int'(bus.out_ready), 1);
                check($sformatf("stream%0d.L", j - 2), int'(bus.out_L), model(stream_s[j - 2], 64));
                check($sformatf("stream%0d.R", j - 2), int'(bus.out_R), model(stream_s[j - 2], 192));
            end
            if (j < 16) begin
                bus.sample_in = 16'(stream_s[j]);
                bus.in_ready  = 1'b1;
            end else begin
                bus.in_ready  = 1'b0;
            end
        end
        @(negedge clk);
        check("stream.idle", int'(bus.out_ready), 0);

        bus.pan_pos = 9'd0;
        strobe(1234, 64, 0, "pre_rst");
        @(negedge clk);
        bus.sample_in = 16'(20000);
        bus.in_ready  = 1'b1;
        @(negedge clk);
        bus.sample_in = 16'(3000);
        reset         = 1'b1;
        @(negedge clk);
        bus.in_ready  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check($sformatf("flush%0d.rdy", j), int'(bus.out_ready), 0);
            check($sformatf("flush%0d.L", j), int'(bus.out_L), 0);
            check($sformatf("flush%0d.R", j), int'(bus.out_R), 0);
            check($sformatf("flush%0d.pos", j), int'(bus.pos_out), 128);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
